// File: rtl/exec_stage.sv
// Execute/writeback sequencer for the 12-bit core: reads operands from the
// synchronous register file, feeds the external ALU, writes back and owns {P,V,K,S,Z}.
module exec_stage #(
    parameter int RA_W   = 3,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [4:0]        issue_op,
    input  logic [3:0]        issue_cond,
    input  logic              issue_pred,
    input  logic              issue_use_imm,
    input  logic [RA_W-1:0]   issue_ra,
    input  logic [RA_W-1:0]   issue_rb,
    input  logic [RA_W-1:0]   issue_rd,
    input  logic [DATA_W-1:0] issue_imm,
    output logic [RA_W-1:0]   rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_we,
    output logic [RA_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_op,
    output logic [4:0]        alu_flg_in,
    input  logic [DATA_W-1:0] alu_q,
    input  logic [4:0]        alu_flg,
    output logic [4:0]        flags,
    output logic              done,
    output logic              skipped
);

    localparam int F_P = 4;
    localparam int F_V = 3;
    localparam int F_K = 2;
    localparam int F_S = 1;
    localparam int F_Z = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RDA,
        S_RDB,
        S_EXE,
        S_WB
    } state_e;

    state_e              state_q, state_d;
    logic [4:0]          op_q, op_d;
    logic [3:0]          cond_q, cond_d;
    logic                use_imm_q, use_imm_d;
    logic [RA_W-1:0]     ra_q, ra_d;
    logic [RA_W-1:0]     rb_q, rb_d;
    logic [RA_W-1:0]     rd_q, rd_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                skip_q, skip_d;
    logic [4:0]          flags_q, flags_d;
    logic [RA_W-1:0]     waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                accept;

    // Condition is evaluated on the flags as they stood before the test op.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [4:0] f);
        logic t;
        t = 1'b0;
        case (cond[2:0])
            3'd0: t = 1'b1;
            3'd1: t = f[F_Z];
            3'd2: t = f[F_S];
            3'd3: t = f[F_K];
            3'd4: t = f[F_V];
            3'd5: t = f[F_S] ^ f[F_V];
            3'd6: t = f[F_Z] | (f[F_S] ^ f[F_V]);
            3'd7: t = f[F_K] | f[F_Z];
            default: t = 1'b0;
        endcase
        return t ^ cond[3];
    endfunction

    assign accept = issue_valid & issue_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its peers, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = (issue_pred && !flags_q[F_P]) ? S_WB : S_RDA;
            S_RDA:  state_d = S_RDB;
            S_RDB:  state_d = S_EXE;
            S_EXE:  state_d = S_WB;
            S_WB:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        issue_ready = (state_q == S_IDLE);
        done        = (state_q == S_WB);
        skipped     = (state_q == S_WB) && skip_q;
        rf_we       = (state_q == S_WB) && !skip_q && !op_q[4];
        rf_raddr    = '0;
        if (state_q == S_RDA) rf_raddr = ra_q;
        if (state_q == S_RDB) rf_raddr = rb_q;
        rf_waddr    = rf_we ? rd_q  : waddr_q;
        rf_wdata    = rf_we ? alu_q : wdata_q;
        alu_a       = a_q;
        alu_b       = b_q;
        alu_op      = op_q;
        alu_flg_in  = flags_q;
        flags       = flags_q;
    end

    // NOTE: every variable gets its hold value first so no path leaves it unassigned.
    always_comb begin
        op_d      = op_q;
        cond_d    = cond_q;
        use_imm_d = use_imm_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        rd_d      = rd_q;
        imm_d     = imm_q;
        a_d       = a_q;
        b_d       = b_q;
        skip_d    = skip_q;
        flags_d   = flags_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        if (accept) begin
            op_d      = issue_op;
            cond_d    = issue_cond;
            use_imm_d = issue_use_imm;
            ra_d      = issue_ra;
            rb_d      = issue_rb;
            rd_d      = issue_rd;
            imm_d     = issue_imm;
            skip_d    = issue_pred && !flags_q[F_P];
        end
        if (state_q == S_RDB) a_d = rf_rdata;
        if (state_q == S_EXE) b_d = use_imm_q ? imm_q : rf_rdata;
        if (state_q == S_WB && !skip_q) begin
            flags_d = op_q[4] ? {cond_eval(cond_q, flags_q), alu_flg[3:0]} : alu_flg;
        end
        if (rf_we) begin
            waddr_d = rd_q;
            wdata_d = alu_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            cond_q    <= '0;
            use_imm_q <= 1'b0;
            ra_q      <= '0;
            rb_q      <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            skip_q    <= 1'b0;
            flags_q   <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            op_q      <= op_d;
            cond_q    <= cond_d;
            use_imm_q <= use_imm_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            rd_q      <= rd_d;
            imm_q     <= imm_d;
            a_q       <= a_d;
            b_q       <= b_d;
            skip_q    <= skip_d;
            flags_q   <= flags_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Bench for exec_stage: register file and ALU models around the DUT, plus an
// instruction-level reference model of registers and flags.
module tb_exec_stage;

    localparam logic [4:0] OP_ADD = 5'h00;
    localparam logic [4:0] OP_ADK = 5'h01;
    localparam logic [4:0] OP_SUB = 5'h02;
    localparam logic [4:0] OP_MOV = 5'h05;
    localparam logic [4:0] OP_CMP = 5'h12;

    typedef struct packed {
        logic [4:0]  op;
        logic [3:0]  cond;
        logic        pred;
        logic        use_imm;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [2:0]  rd;
        logic [11:0] imm;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rf_clr = 1'b1;
    logic        issue_valid = 1'b0, issue_ready;
    logic [4:0]  issue_op = '0;
    logic [3:0]  issue_cond = '0;
    logic        issue_pred = 1'b0, issue_use_imm = 1'b0;
    logic [2:0]  issue_ra = '0, issue_rb = '0, issue_rd = '0;
    logic [11:0] issue_imm = '0;
    logic [2:0]  rf_raddr, rf_waddr;
    logic [11:0] rf_rdata, rf_wdata;
    logic        rf_we;
    logic [11:0] alu_a, alu_b, alu_q;
    logic [4:0]  alu_op, alu_flg_in, alu_flg, flags;
    logic        done, skipped;

    logic [11:0] regs [8];
    logic [11:0] exp_regs [8];
    logic [4:0]  exp_flags;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    exec_stage #(.RA_W(3), .DATA_W(12)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_cond(issue_cond), .issue_pred(issue_pred),
        .issue_use_imm(issue_use_imm), .issue_ra(issue_ra), .issue_rb(issue_rb),
        .issue_rd(issue_rd), .issue_imm(issue_imm),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_flg_in(alu_flg_in),
        .alu_q(alu_q), .alu_flg(alu_flg),
        .flags(flags), .done(done), .skipped(skipped)
    );

    // ALU: op[3:0] 0 ADD, 1 ADK (add with K), 2 SUB (K=borrow), 3 AND, 4 XOR, else MOV b.
    function automatic logic [16:0] alu_fn(input logic [4:0] op, input logic [11:0] a,
                                           input logic [11:0] b, input logic [4:0] fin);
        int sum;
        logic [11:0] r;
        logic v, k;
        v = 1'b0;
        k = 1'b0;
        sum = 0;
        case (op[3:0])
            4'd0, 4'd1: begin
                sum = int'(a) + int'(b) + ((op[3:0] == 4'd1) ? int'(fin[2]) : 0);
                r = sum[11:0];
                k = (sum > 4095);
                v = (a[11] == b[11]) && (r[11] != a[11]);
            end
            4'd2: begin
                sum = int'(a) - int'(b);
                r = sum[11:0];
                k = (a < b);
                v = (a[11] != b[11]) && (r[11] != a[11]);
            end
            4'd3: r = a & b;
            4'd4: r = a ^ b;
            default: r = b;
        endcase
        return {fin[4], v, k, r[11], (r == 12'd0), r};
    endfunction

    function automatic logic cond_ref(input logic [3:0] c, input logic [4:0] f);
        logic z, s, k, v, t;
        z = f[0]; s = f[1]; k = f[2]; v = f[3];
        case (c[2:0])
            3'd0: t = 1'b1;
            3'd1: t = z;
            3'd2: t = s;
            3'd3: t = k;
            3'd4: t = v;
            3'd5: t = s ^ v;
            3'd6: t = z | (s ^ v);
            default: t = k | z;
        endcase
        return c[3] ? !t : t;
    endfunction

    always_comb {alu_flg, alu_q} = alu_fn(alu_op, alu_a, alu_b, alu_flg_in);

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (rf_we) begin
            regs[rf_waddr] <= rf_wdata;
        end
        rf_rdata <= regs[rf_raddr];
    end

    function automatic instr_t mk(input logic [4:0] op, input logic [3:0] cond, input logic pred,
                                  input logic use_imm, input logic [2:0] ra, input logic [2:0] rb,
                                  input logic [2:0] rd, input logic [11:0] imm);
        instr_t t;
        t.op = op; t.cond = cond; t.pred = pred; t.use_imm = use_imm;
        t.ra = ra; t.rb = rb; t.rd = rd; t.imm = imm;
        return t;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        logic [3:0] lo;
        lo = 4'($urandom_range(0, 5));
        t.op = {($urandom_range(0, 3) == 0), lo};
        t.cond = 4'($urandom);
        t.pred = ($urandom_range(0, 2) == 0);
        t.use_imm = 1'($urandom);
        t.ra = 3'($urandom);
        t.rb = 3'($urandom);
        t.rd = 3'($urandom);
        t.imm = 12'($urandom);
        return t;
    endfunction

    task automatic drive(input instr_t t);
        issue_op = t.op; issue_cond = t.cond; issue_pred = t.pred;
        issue_use_imm = t.use_imm; issue_ra = t.ra; issue_rb = t.rb;
        issue_rd = t.rd; issue_imm = t.imm;
    endtask

    // Retire one instruction in the reference model; returns what WB should show.
    task automatic model_step(input instr_t t, output logic skip, output logic wr,
                              output logic [11:0] a, output logic [11:0] b, output logic [11:0] r);
        logic [16:0] res;
        skip = t.pred && !exp_flags[4];
        a = exp_regs[t.ra];
        b = t.use_imm ? t.imm : exp_regs[t.rb];
        res = alu_fn(t.op, a, b, exp_flags);
        r = res[11:0];
        wr = !skip && !t.op[4];
        if (!skip) exp_flags = t.op[4] ? {cond_ref(t.cond, exp_flags), res[15:12]} : res[16:12];
        if (wr) exp_regs[t.rd] = r;
    endtask

    task automatic run_instr(input instr_t t, input string name);
        logic skip, wr;
        logic [11:0] a, b, r;
        int done_at;
        model_step(t, skip, wr, a, b, r);
        @(negedge clk);
        drive(t);
        issue_valid = 1'b1;
        total++;
        if (issue_ready !== 1'b1) begin
            bad++; $display("FAIL %s.ready_before: got %b want 1", name, issue_ready);
        end
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        drive(rand_instr());
        done_at = 0;
        for (int k = 1; k <= 8 && done_at == 0; k++) begin
            @(negedge clk);
            if (!skip && k == 1) begin
                total++;
                if (rf_raddr !== t.ra) begin
                    bad++; $display("FAIL %s.raddr_a: got %0d want %0d", name, rf_raddr, t.ra);
                end
            end
            if (!skip && k == 2) begin
                total++;
                if (rf_raddr !== t.rb) begin
                    bad++; $display("FAIL %s.raddr_b: got %0d want %0d", name, rf_raddr, t.rb);
                end
            end
            if (done === 1'b1) begin
                done_at = k;
                total++;
                if (skipped !== skip || rf_we !== wr) begin
                    bad++; $display("FAIL %s.wb_ctl: skipped=%b rf_we=%b want %b %b", name, skipped, rf_we, skip, wr);
                end
                if (wr) begin
                    total++;
                    if (rf_waddr !== t.rd || rf_wdata !== r) begin
                        bad++; $display("FAIL %s.write: got r%0d=%h want r%0d=%h", name, rf_waddr, rf_wdata, t.rd, r);
                    end
                end
                if (!skip) begin
                    total++;
                    if (alu_a !== a || alu_b !== b || alu_op !== t.op) begin
                        bad++; $display("FAIL %s.alu_in: got %h %h %h want %h %h %h", name, alu_a, alu_b, alu_op, a, b, t.op);
                    end
                end
            end else if (rf_we !== 1'b0 || skipped !== 1'b0) begin
                total++; bad++;
                $display("FAIL %s.early_strobe: rf_we=%b skipped=%b in cycle %0d want 0 0", name, rf_we, skipped, k);
            end
        end
        total++;
        if (done_at != (skip ? 1 : 4)) begin
            bad++; $display("FAIL %s.latency: got %0d want %0d", name, done_at, skip ? 1 : 4);
        end
        @(negedge clk);
        total++;
        if (issue_ready !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL %s.ready_after: ready=%b done=%b want 1 0", name, issue_ready, done);
        end
        total++;
        if (flags !== exp_flags) begin
            bad++; $display("FAIL %s.flags: got %b want %b", name, flags, exp_flags);
        end
    endtask

    task automatic check_regs(input string name);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (regs[i] !== exp_regs[i]) begin
                bad++; $display("FAIL %s.r%0d: got %h want %h", name, i, regs[i], exp_regs[i]);
            end
        end
    endtask

    task automatic test_reset();
        total++;
        if (issue_ready !== 1'b1 || flags !== 5'd0 || done !== 1'b0 || skipped !== 1'b0 || rf_we !== 1'b0) begin
            bad++; $display("FAIL reset.ctl: ready=%b flags=%b done=%b skipped=%b we=%b want 1 00000 0 0 0",
                            issue_ready, flags, done, skipped, rf_we);
        end
        total++;
        if (alu_a !== 12'd0 || alu_b !== 12'd0 || alu_op !== 5'd0 || rf_raddr !== 3'd0) begin
            bad++; $display("FAIL reset.regs: a=%h b=%h op=%h raddr=%0d want zeros", alu_a, alu_b, alu_op, rf_raddr);
        end
    endtask

    task automatic test_add_overflow();
        run_instr(mk(OP_MOV, 4'd0, 1'b0, 1'b1, 3'd0, 3'd0, 3'd1, 12'h7FF), "ld_r1");
        run_instr(mk(OP_MOV, 4'd0, 1'b0, 1'b1, 3'd0, 3'd0, 3'd2, 12'h001), "ld_r2");
        run_instr(mk(OP_ADD, 4'd0, 1'b0, 1'b0, 3'd1, 3'd2, 3'd3, 12'h000), "add_ovf");
        total++;
        if (regs[3] !== 12'h800 || flags !== 5'b01010) begin
            bad++; $display("FAIL add_ovf.result: r3=%h flags=%b want 800 01010", regs[3], flags);
        end
    endtask

    task automatic test_sub_cond();
        run_instr(mk(OP_MOV, 4'd0, 1'b0, 1'b1, 3'd0, 3'd0, 3'd4, 12'h005), "ld_r4");
        run_instr(mk(OP_SUB, 4'd0, 1'b0, 1'b1, 3'd4, 3'd0, 3'd4, 12'h005), "sub_imm");
        total++;
        if (regs[4] !== 12'h000 || flags[0] !== 1'b1 || flags[2] !== 1'b0) begin
            bad++; $display("FAIL sub_imm.result: r4=%h Z=%b K=%b want 000 1 0", regs[4], flags[0], flags[2]);
        end
        run_instr(mk(OP_CMP, 4'd1, 1'b0, 1'b1, 3'd4, 3'd0, 3'd6, 12'h000), "test_z");
        total++;
        if (flags[4] !== 1'b1) begin
            bad++; $display("FAIL test_z.p: got %b want 1", flags[4]);
        end
        run_instr(mk(OP_CMP, 4'd9, 1'b0, 1'b1, 3'd4, 3'd0, 3'd6, 12'h000), "test_nz");
        total++;
        if (flags[4] !== 1'b0) begin
            bad++; $display("FAIL test_nz.p: got %b want 0", flags[4]);
        end
        check_regs("sub_cond");
    endtask

    task automatic test_pred();
        run_instr(mk(OP_ADD, 4'd0, 1'b1, 1'b0, 3'd1, 3'd2, 3'd5, 12'h000), "pred_skip");
        total++;
        if (regs[5] !== 12'h000) begin
            bad++; $display("FAIL pred_skip.r5: got %h want 000", regs[5]);
        end
        run_instr(mk(OP_CMP, 4'd0, 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 12'h000), "set_p");
        run_instr(mk(OP_ADD, 4'd0, 1'b1, 1'b0, 3'd1, 3'd2, 3'd5, 12'h000), "pred_exec");
        total++;
        if (regs[5] !== 12'h800) begin
            bad++; $display("FAIL pred_exec.r5: got %h want 800", regs[5]);
        end
    endtask

    task automatic test_carry();
        run_instr(mk(OP_MOV, 4'd0, 1'b0, 1'b1, 3'd0, 3'd0, 3'd5, 12'hFFF), "ld_r5");
        run_instr(mk(OP_MOV, 4'd0, 1'b0, 1'b1, 3'd0, 3'd0, 3'd6, 12'h001), "ld_r6");
        run_instr(mk(OP_MOV, 4'd0, 1'b0, 1'b1, 3'd0, 3'd0, 3'd1, 12'h000), "ld_r1z");
        run_instr(mk(OP_ADD, 4'd0, 1'b0, 1'b0, 3'd5, 3'd6, 3'd7, 12'h000), "add_carry");
        total++;
        if (regs[7] !== 12'h000 || flags[2] !== 1'b1) begin
            bad++; $display("FAIL add_carry.result: r7=%h K=%b want 000 1", regs[7], flags[2]);
        end
        run_instr(mk(OP_ADK, 4'd0, 1'b0, 1'b1, 3'd1, 3'd0, 3'd1, 12'h000), "adk");
        total++;
        if (regs[1] !== 12'h001 || flags[2] !== 1'b0) begin
            bad++; $display("FAIL adk.result: r1=%h K=%b want 001 0", regs[1], flags[2]);
        end
    endtask

    task automatic test_back_to_back();
        instr_t q [3];
        int acc [3];
        int n, cyc;
        logic skip, wr;
        logic [11:0] a, b, r;
        q[0] = mk(OP_MOV, 4'd0, 1'b0, 1'b1, 3'd0, 3'd0, 3'd2, 12'h123);
        q[1] = mk(OP_ADD, 4'd0, 1'b0, 1'b0, 3'd2, 3'd2, 3'd3, 12'h000);
        q[2] = mk(OP_SUB, 4'd0, 1'b0, 1'b0, 3'd3, 3'd2, 3'd2, 12'h000);
        n = 0;
        cyc = 0;
        @(negedge clk);
        issue_valid = 1'b1;
        while (n < 3 && cyc < 40) begin
            if (issue_ready === 1'b1) drive(q[n]);
            else drive(rand_instr());
            @(posedge clk);
            cyc++;
            if (issue_ready === 1'b1) begin
                acc[n] = cyc;
                model_step(q[n], skip, wr, a, b, r);
                n++;
            end
            @(negedge clk);
            if (n == 3) issue_valid = 1'b0;
        end
        issue_valid = 1'b0;
        total++;
        if (n != 3) begin
            bad++; $display("FAIL b2b.accepts: got %0d want 3", n);
        end else begin
            total++;
            if (acc[1] - acc[0] != 5 || acc[2] - acc[1] != 5) begin
                bad++; $display("FAIL b2b.spacing: got %0d %0d want 5 5", acc[1] - acc[0], acc[2] - acc[1]);
            end
        end
        repeat (6) @(negedge clk);
        total++;
        if (flags !== exp_flags || issue_ready !== 1'b1) begin
            bad++; $display("FAIL b2b.flags: got %b ready=%b want %b 1", flags, issue_ready, exp_flags);
        end
        check_regs("b2b");
    endtask

    task automatic test_reset_mid();
        int strobes;
        run_instr(mk(OP_MOV, 4'd0, 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 12'h800), "ld_r0");
        @(negedge clk);
        drive(mk(OP_ADD, 4'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd2, 12'h000));
        issue_valid = 1'b1;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        strobes = 0;
        repeat (3) begin
            @(negedge clk);
            if (rf_we === 1'b1 || done === 1'b1) strobes++;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_flags = '0;
        total++;
        if (issue_ready !== 1'b1 || flags !== 5'd0) begin
            bad++; $display("FAIL rst_mid.state: ready=%b flags=%b want 1 00000", issue_ready, flags);
        end
        repeat (6) begin
            @(negedge clk);
            if (rf_we === 1'b1 || done === 1'b1) strobes++;
        end
        total++;
        if (strobes != 0) begin
            bad++; $display("FAIL rst_mid.strobes: got %0d want 0", strobes);
        end
        check_regs("rst_mid");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) run_instr(rand_instr(), $sformatf("rand%0d", i));
        check_regs("random");
    endtask

    initial begin
        for (int i = 0; i < 8; i++) exp_regs[i] = '0;
        exp_flags = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rf_clr = 1'b0;
        test_reset();
        test_add_overflow();
        test_sub_cond();
        test_pred();
        test_carry();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
